// File: rtl/b14_resp_pkg.sv
// Shared definitions for the b14 memory responder: FSM states, bus widths,
// the out-of-range read pattern and the write-trace entry layout.
package b14_resp_pkg;

    localparam int ADDR_W  = 20;
    localparam int DATA_W  = 31;
    localparam int TRACE_W = ADDR_W + DATA_W;

    // Returned for any read whose address lies outside the RAM.
    localparam logic [DATA_W-1:0] OOR_DATA = 31'h7FFF_FFFF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } trace_entry_t;

endpackage

// File: rtl/b14_trace_fifo.sv
// Synchronous FIFO for the write trace. A push while full is accepted if a
// pop happens in the same cycle; otherwise it is dropped and ovf_o latches.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module b14_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 51
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] head_o,
    output logic             ovf_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             ovf_q;

    logic full;
    logic do_pop;
    logic do_push;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && (count_q != '0);
    assign do_push = push_i && (!full || do_pop);

    assign valid_o = (count_q != '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign ovf_o   = ovf_q;

    // Entry storage; no reset needed, validity is tracked by count_q.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
            if (push_i && full && !do_pop) ovf_q <= 1'b1;
        end
    end

endmodule

// File: rtl/b14_mem_responder.sv
// Word-addressed RAM responder for the b14 core. Reads complete RD_LATENCY
// cycles after the request (latest request wins); the RAM is read at
// completion so recent writes are visible. Optional write trace FIFO is
// built only when B14_MEM_RESP_TRACE_EN is defined.
module b14_mem_responder
    import b14_resp_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int RD_LATENCY  = 2,
    parameter int TRACE_DEPTH = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [19:0] addr,
    input  logic [30:0] datao,
    input  logic        rd,
    input  logic        wr,
    output logic [30:0] datai,
    output logic        busy,
    output logic [7:0]  err_cnt,
    output logic        trace_valid,
    input  logic        trace_ready,
    output logic [50:0] trace_data,
    output logic        trace_ovf
);

    localparam int CNT_W = 2;

    logic [DATA_W-1:0]     ram_q [2**DEPTH_LOG2];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  oor_q, oor_d;
    logic [DATA_W-1:0]     datai_q, datai_d;
    logic [7:0]            err_q;

    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  rd_req;
    logic                  err_evt;

    assign in_range = (addr[ADDR_W-1:DEPTH_LOG2] == '0);
    assign idx      = addr[DEPTH_LOG2-1:0];
    // A collision is a write; the read side is simply ignored.
    assign rd_req   = rd && !wr;
    assign err_evt  = (rd && wr) || (rd_req && !in_range) || (wr && !in_range);

    assign datai   = datai_q;
    assign busy    = (state_q == WAIT);
    assign err_cnt = err_q;

    // RAM write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (wr && in_range) begin
            ram_q[idx] <= datao;
        end
    end

    // Read FSM next state: a new read always restarts, otherwise count down.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        datai_d = datai_q;
        if (rd_req) begin
            state_d = WAIT;
            cnt_d   = CNT_W'(RD_LATENCY - 1);
            idx_d   = idx;
            oor_d   = !in_range;
        end else if (state_q == WAIT) begin
            if (cnt_q == '0) begin
                state_d = IDLE;
                datai_d = oor_q ? OOR_DATA : ram_q[idx_q];
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Read FSM state register and response hold register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            datai_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            datai_q <= datai_d;
        end
    end

    // Saturating error counter; at most one increment per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= '0;
        end else if (err_evt && (err_q != 8'hFF)) begin
            err_q <= err_q + 8'd1;
        end
    end

`ifdef B14_MEM_RESP_TRACE_EN
    trace_entry_t push_entry;
    assign push_entry = '{addr: addr, data: datao};

    b14_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (TRACE_W)
    ) u_trace_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (wr && in_range),
        .push_data_i (push_entry),
        .pop_i       (trace_ready),
        .valid_o     (trace_valid),
        .head_o      (trace_data),
        .ovf_o       (trace_ovf)
    );
`else
    logic unused_trace_ready;
    assign unused_trace_ready = trace_ready;
    assign trace_valid = 1'b0;
    assign trace_data  = '0;
    assign trace_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_b14_mem_responder.sv
// Testbench for b14_mem_responder. Expectations come from a RAM model,
// an error-count model and a trace-entry queue kept by the bench.
module tb_b14_mem_responder;

    localparam int LAT = 2;
    localparam int TD  = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [19:0] addr  = '0;
    logic [30:0] datao = '0;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic        trace_ready = 1'b0;
    logic [30:0] datai;
    logic        busy;
    logic [7:0]  err_cnt;
    logic        trace_valid;
    logic [50:0] trace_data;
    logic        trace_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [30:0] exp_q[$];
    logic [50:0] trace_q[$];
    logic [30:0] model_mem [256];
    logic [7:0]  err_m = '0;
    logic        ovf_m = 1'b0;

    always #5 clock = ~clock;

    b14_mem_responder #(
        .DEPTH_LOG2  (8),
        .RD_LATENCY  (LAT),
        .TRACE_DEPTH (TD)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .addr        (addr),
        .datao       (datao),
        .rd          (rd),
        .wr          (wr),
        .datai       (datai),
        .busy        (busy),
        .err_cnt     (err_cnt),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_data  (trace_data),
        .trace_ovf   (trace_ovf)
    );

    function automatic logic [30:0] exp_rd(input logic [19:0] a);
        return (a[19:8] == 12'd0) ? model_mem[a[7:0]] : 31'h7FFF_FFFF;
    endfunction

    task automatic bump_err();
        err_m = (err_m == 8'hFF) ? 8'hFF : err_m + 8'd1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1; rd = 1'b0; wr = 1'b0; trace_ready = 1'b0;
        repeat (cycles) @(negedge clock);
        reset = 1'b0;
        err_m = '0; ovf_m = 1'b0;
        trace_q.delete(); exp_q.delete();
    endtask

    // One write cycle with trace_ready low; updates all bench models.
    task automatic do_write(input logic [19:0] a, input logic [30:0] d);
        addr = a; datao = d; wr = 1'b1; rd = 1'b0;
        @(negedge clock);
        wr = 1'b0;
        if (a[19:8] == 12'd0) begin
            model_mem[a[7:0]] = d;
`ifdef B14_MEM_RESP_TRACE_EN
            if (trace_q.size() < TD) trace_q.push_back({a, d});
            else ovf_m = 1'b1;
`endif
        end else begin
            bump_err();
        end
    endtask

    // One read-request cycle; returns one negedge after the sampling edge.
    task automatic drive_rd(input logic [19:0] a);
        addr = a; rd = 1'b1; wr = 1'b0;
        @(negedge clock);
        rd = 1'b0;
        if (a[19:8] != 12'd0) bump_err();
    endtask

    task automatic test_reset();
        do_reset(3);
        n_cmp++; if (datai !== 31'd0) begin n_fail++; $display("FAIL reset_datai: got %h expected 0", datai); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_err: got %h expected 0", err_cnt); end
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: got %b expected 0", trace_valid); end
        n_cmp++; if (trace_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_tovf: got %b expected 0", trace_ovf); end
    endtask

    task automatic test_basic_read();
        logic [30:0] prev, e;
        do_write(20'h00005, 31'h1234567);
        prev = datai;
        exp_q.push_back(exp_rd(20'h00005));
        drive_rd(20'h00005);
        for (int k = 0; k < LAT; k++) begin
            n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_c%0d: got %b expected 1", k, busy); end
            n_cmp++; if (datai !== prev) begin n_fail++; $display("FAIL basic_hold_c%0d: got %h expected %h", k, datai, prev); end
            @(negedge clock);
        end
        e = exp_q.pop_front();
        n_cmp++; if (datai !== e) begin n_fail++; $display("FAIL basic_data: got %h expected %h", datai, e); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done: got %b expected 0", busy); end
        n_cmp++; if (err_cnt !== err_m) begin n_fail++; $display("FAIL basic_err: got %h expected %h", err_cnt, err_m); end
    endtask

    task automatic test_oor();
        logic [30:0] e;
        do_reset(2);
        exp_q.push_back(exp_rd(20'h10000));
        drive_rd(20'h10000);
        n_cmp++; if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL oor_rd_err: got %h expected 01", err_cnt); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL oor_busy: got %b expected 1", busy); end
        repeat (LAT) @(negedge clock);
        e = exp_q.pop_front();
        n_cmp++; if (datai !== e) begin n_fail++; $display("FAIL oor_data: got %h expected %h", datai, e); end
        do_write(20'h10000, 31'h0000001);
        n_cmp++; if (err_cnt !== 8'd2) begin n_fail++; $display("FAIL oor_wr_err: got %h expected 02", err_cnt); end
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL oor_no_trace: got %b expected 0", trace_valid); end
    endtask

    task automatic test_collision();
        logic [30:0] e;
        addr = 20'h00003; datao = 31'h55; rd = 1'b1; wr = 1'b1;
        @(negedge clock);
        rd = 1'b0; wr = 1'b0;
        model_mem[3] = 31'h55;
        bump_err();
`ifdef B14_MEM_RESP_TRACE_EN
        if (trace_q.size() < TD) trace_q.push_back({20'h00003, 31'h55}); else ovf_m = 1'b1;
`endif
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL coll_idle: got %b expected 0", busy); end
        n_cmp++; if (err_cnt !== err_m) begin n_fail++; $display("FAIL coll_err: got %h expected %h", err_cnt, err_m); end
        exp_q.push_back(exp_rd(20'h00003));
        drive_rd(20'h00003);
        repeat (LAT) @(negedge clock);
        e = exp_q.pop_front();
        n_cmp++; if (datai !== e) begin n_fail++; $display("FAIL coll_data: got %h expected %h", datai, e); end
    endtask

    task automatic test_restart();
        logic [30:0] prev, e;
        do_write(20'h00001, 31'h0AAAA01);
        do_write(20'h00002, 31'h0BBBB02);
        prev = datai;
        addr = 20'h00001; rd = 1'b1; wr = 1'b0;
        @(negedge clock);
        addr = 20'h00002;
        exp_q.push_back(exp_rd(20'h00002));
        @(negedge clock);
        rd = 1'b0;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL restart_busy: got %b expected 1", busy); end
        repeat (LAT - 1) @(negedge clock);
        n_cmp++; if (datai !== prev) begin n_fail++; $display("FAIL restart_no_early: got %h expected %h", datai, prev); end
        @(negedge clock);
        e = exp_q.pop_front();
        n_cmp++; if (datai !== e) begin n_fail++; $display("FAIL restart_data: got %h expected %h", datai, e); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_done: got %b expected 0", busy); end
    endtask

    task automatic test_rd_after_wr();
        logic [30:0] e;
        do_write(20'h00007, 31'h1357BDF);
        exp_q.push_back(exp_rd(20'h00007));
        drive_rd(20'h00007);
        repeat (LAT) @(negedge clock);
        e = exp_q.pop_front();
        n_cmp++; if (datai !== e) begin n_fail++; $display("FAIL rdwr_next: got %h expected %h", datai, e); end
        // Overwrite the word while its read is still in flight.
        do_write(20'h00008, 31'h2222222);
        drive_rd(20'h00008);
        do_write(20'h00008, 31'h3333333);
        exp_q.push_back(exp_rd(20'h00008));
        repeat (LAT - 1) @(negedge clock);
        e = exp_q.pop_front();
        n_cmp++; if (datai !== e) begin n_fail++; $display("FAIL rdwr_inflight: got %h expected %h", datai, e); end
    endtask

    task automatic test_random();
        logic [19:0] a;
        logic [30:0] d, e;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 3) a = {12'($urandom_range(1, 4095)), 8'($urandom_range(0, 255))};
            else            a = {12'd0, 8'($urandom_range(0, 255))};
            d = 31'($urandom);
            do_write(a, d);
            exp_q.push_back(exp_rd(a));
            drive_rd(a);
            repeat (LAT) @(negedge clock);
            e = exp_q.pop_front();
            n_cmp++; if (datai !== e) begin n_fail++; $display("FAIL rand_data_%0d: got %h expected %h", i, datai, e); end
            n_cmp++; if (err_cnt !== err_m) begin n_fail++; $display("FAIL rand_err_%0d: got %h expected %h", i, err_cnt, err_m); end
        end
    endtask

`ifdef B14_MEM_RESP_TRACE_EN
    task automatic test_trace();
        int popped;
        logic [50:0] e;
        do_reset(2);
        for (int ph = 0; ph < 2; ph++) begin
            for (int i = 0; i < TD + ph; i++) do_write(20'(32'h40 + i), 31'($urandom));
            n_cmp++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL trace_full_valid_p%0d: got %b expected 1", ph, trace_valid); end
            n_cmp++; if (trace_ovf !== ovf_m) begin n_fail++; $display("FAIL trace_ovf_p%0d: got %b expected %b", ph, trace_ovf, ovf_m); end
            if (ph == 0) begin
                // Push and pop together while full.
                addr = 20'h00050; datao = 31'h77; wr = 1'b1; trace_ready = 1'b1;
                @(negedge clock);
                wr = 1'b0; trace_ready = 1'b0;
                model_mem[8'h50] = 31'h77;
                void'(trace_q.pop_front());
                trace_q.push_back({20'h00050, 31'h77});
                n_cmp++; if (trace_ovf !== 1'b0) begin n_fail++; $display("FAIL trace_pushpop_ovf: got %b expected 0", trace_ovf); end
            end
            popped = 0;
            trace_ready = 1'b1;
            for (int k = 0; k < 20 && trace_valid === 1'b1; k++) begin
                e = (trace_q.size() != 0) ? trace_q.pop_front() : '0;
                n_cmp++; if (trace_data !== e) begin n_fail++; $display("FAIL trace_data_p%0d_%0d: got %h expected %h", ph, k, trace_data, e); end
                popped++;
                @(negedge clock);
            end
            trace_ready = 1'b0;
            n_cmp++; if (popped !== TD) begin n_fail++; $display("FAIL trace_count_p%0d: got %0d expected %0d", ph, popped, TD); end
        end
        trace_ready = 1'b1;
        @(negedge clock);
        trace_ready = 1'b0;
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL trace_pop_empty: got %b expected 0", trace_valid); end
        n_cmp++; if (trace_ovf !== 1'b1) begin n_fail++; $display("FAIL trace_ovf_sticky: got %b expected 1", trace_ovf); end
    endtask
`else
    task automatic test_trace();
        trace_ready = 1'b1;
        for (int i = 0; i < TD + 1; i++) do_write(20'(32'h40 + i), 31'($urandom));
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL trace_off_valid: got %b expected 0", trace_valid); end
        n_cmp++; if (trace_data !== 51'd0) begin n_fail++; $display("FAIL trace_off_data: got %h expected 0", trace_data); end
        n_cmp++; if (trace_ovf !== 1'b0) begin n_fail++; $display("FAIL trace_off_ovf: got %b expected 0", trace_ovf); end
        trace_ready = 1'b0;
    endtask
`endif

    task automatic test_err_sat();
        do_reset(2);
        for (int i = 0; i < 300; i++) begin
            do_write(20'h80000, 31'(i));
            if (i % 50 == 49) begin
                n_cmp++; if (err_cnt !== err_m) begin n_fail++; $display("FAIL errsat_%0d: got %h expected %h", i, err_cnt, err_m); end
            end
        end
        n_cmp++; if (err_cnt !== 8'hFF) begin n_fail++; $display("FAIL errsat_final: got %h expected ff", err_cnt); end
    endtask

    task automatic test_reset_mid_wait();
        do_write(20'h00009, 31'h3C3C3C3);
        drive_rd(20'h00009);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstwait_busy: got %b expected 1", busy); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        err_m = '0; ovf_m = 1'b0; trace_q.delete(); exp_q.delete();
        n_cmp++; if (datai !== 31'd0) begin n_fail++; $display("FAIL rstwait_datai: got %h expected 0", datai); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstwait_busy0: got %b expected 0", busy); end
        n_cmp++; if (err_cnt !== 8'd0) begin n_fail++; $display("FAIL rstwait_err: got %h expected 0", err_cnt); end
        n_cmp++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL rstwait_tvalid: got %b expected 0", trace_valid); end
        repeat (LAT + 1) @(negedge clock);
        n_cmp++; if (datai !== 31'd0) begin n_fail++; $display("FAIL rstwait_abandon: got %h expected 0", datai); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstwait_idle: got %b expected 0", busy); end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_basic_read();
        test_oor();
        test_collision();
        test_restart();
        test_rd_after_wr();
        test_random();
        test_trace();
        test_err_sat();
        test_reset_mid_wait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/b14_mem_responder.md
B14_MEM_RESPONDER -- requirements
Module: b14_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8: word-addressed RAM holds 2^DEPTH_LOG2 words of 31 bits.
REQ-002 SHALL have parameter RD_LATENCY, default 2, legal range 1..4: cycles from a sampled rd to updated datai.
REQ-003 SHALL have parameter TRACE_DEPTH, default 8, power of two: write-trace FIFO entries.
REQ-004 clock  input  1  single clock; all logic on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 addr  input  20  word address driven by b14.
REQ-007 datao  input  31  write data driven by b14.
REQ-008 rd  input  1  read request, sampled each cycle.
REQ-009 wr  input  1  write request, sampled each cycle.
REQ-010 datai  output  31  read response to b14.
REQ-011 busy  output  1  high while a read is in flight.
REQ-012 err_cnt  output  8  saturating count of out-of-range accesses and rd/wr collisions.
REQ-013 trace_valid  output  1  trace FIFO non-empty.
REQ-014 trace_ready  input  1  consumer pops the head when trace_valid && trace_ready.
REQ-015 trace_data  output  51  head entry {addr[19:0], datao[30:0]}.
REQ-016 trace_ovf  output  1  sticky: a write was dropped because the FIFO was full.

Function
REQ-017 An address is in range iff addr[19:DEPTH_LOG2] == 0; RAM index is addr[DEPTH_LOG2-1:0].
REQ-018 Cycle with wr=1 and address in range: RAM word written with datao at that edge.
REQ-019 Cycle with rd=1, wr=0: FSM IDLE->WAIT, latency counter loads RD_LATENCY-1, RAM index and range flag captured.
REQ-020 In WAIT the counter decrements each cycle; at zero, datai updates and FSM returns to IDLE; datai therefore changes exactly RD_LATENCY cycles after the rd edge.
REQ-021 New rd while in WAIT restarts the read with the new address (latest wins); the earlier read never updates datai.
REQ-022 datai holds its last value between read completions.
REQ-023 Out-of-range read returns 31'h7FFF_FFFF; err_cnt increments once at the rd edge.
REQ-024 Out-of-range write is dropped and err_cnt increments.
REQ-025 rd and wr high together: the write proceeds, the read is ignored (no state change), err_cnt increments once.
REQ-026 Read of a word written RD_LATENCY-1 or fewer cycles earlier returns the new value (RAM read at completion, not at request).
REQ-027 err_cnt saturates at 8'hFF.
REQ-028 busy = (state == WAIT).
REQ-029 Each in-range write pushes {addr, datao} into the trace FIFO; a push when full drops the entry and sets trace_ovf.
REQ-030 Simultaneous push and pop when full: the pop frees a slot and the push is accepted; trace_ovf is not set.
REQ-031 trace_data is valid only while trace_valid=1; pop on empty is ignored.

Reset
REQ-032 Reset sets state IDLE, datai=0, busy=0, err_cnt=0, trace FIFO empty, trace_valid=0, trace_ovf=0.
REQ-033 Reset during WAIT abandons the read; datai stays 0.
REQ-034 RAM contents are not reset.

Configuration
REQ-035 Macro B14_MEM_RESP_TRACE_EN: when defined, the trace FIFO and its ports are functional as described above.
REQ-036 Without it, the FIFO is not built; trace_valid=0, trace_data=0, and trace_ovf=0 constantly; trace_ready is ignored.

Structure
REQ-037 Shared package b14_resp_pkg SHALL hold the FSM state enum (IDLE, WAIT), the ADDR_W=20 and DATA_W=31 constants, the OOR_DATA constant, and the trace entry struct typedef.
REQ-038 Trace FIFO SHALL be a sub-module b14_trace_fifo (synchronous, parameterised depth and width).

Verification
REQ-039 Write addr=0x00005 data=0x1234567, then rd addr=0x00005 at cycle t -> datai=0x1234567 at t+2, busy high for cycles t+1..t+2.
REQ-040 rd addr=0x10000 -> datai=0x7FFFFFFF after latency, err_cnt=1; wr to 0x10000 -> err_cnt=2, no trace entry.
REQ-041 rd and wr high together at addr 3 with data 0x55 -> RAM[3]=0x55, state stays IDLE, err_cnt+1.
REQ-042 rd addr 1 then rd addr 2 on the next cycle -> only the addr-2 data appears, 2 cycles after the second rd.
REQ-043 9 writes with trace_ready=0 (TRACE_DEPTH=8) -> 8 entries held, trace_ovf=1; then a write and a pop in the same cycle while full -> entry accepted.
REQ-044 Reset asserted mid-WAIT -> datai=0, busy=0 next cycle, err_cnt=0, FIFO empty.
